lp4_wr_burst_tx: RTL and testbench
==================================

Name: lp4_wr_burst_tx

Overview:
- Controller-side LPDDR4 channel-A write-burst transmitter: the initiator for the memory model's write-receive path.
- Accepts one 16-beat write burst per valid/ready handshake and issues the write command (CS=1, CA=4).
- After write latency WL it drives a 2-cycle DQS preamble, 8 cycles of DDR data (2 beats/cycle), a 1-cycle postamble, then releases the bus.
- Outputs are SDR rise/fall pairs in the CK domain, consumed by the downstream DDR output cells.

Parameters:
- WL, 6, cycles from the command cycle to the first preamble cycle; legal range 2..63.
- DQ_W, 16, DQ width per beat.
- BL, 16, beats per burst; fixed; must be even.
- CA_WR, 6'd4, CA code driven in the command cycle.

Ports:
- CK  input  1  controller clock; all logic on its rising edge.
- RESET_N  input  1  reset, asynchronous, active-high.
- wr_valid  input  1  burst request valid.
- wr_ready  output  1  request accepted when wr_valid&&wr_ready.
- wr_data  input  BL*DQ_W  burst data; beat k = wr_data[DQ_W*k +: DQ_W].
- wr_mask  input  BL*2  byte mask; beat k = wr_mask[2k +: 2].
- cs  output  1  chip select.
- ca  output  6  command/address.
- dq_r, dq_f  output  DQ_W each  rise-phase / fall-phase beat.
- dmi_r, dmi_f  output  2 each  mask per phase.
- dq_oe  output  1  DQ/DMI output enable.
- dqs_t_r, dqs_t_f  output  2 each  DQS_T level per phase; DQS_C is the complement, generated downstream.
- dqs_oe  output  1  DQS output enable.
- busy  output  1  FSM not IDLE.
- done  output  1  one-cycle pulse in the POST cycle.

Behaviour:
- Reset values: cs=0, ca=0, dq_r=dq_f=0, dmi=0, dq_oe=0, dqs_t_r=dqs_t_f=0, dqs_oe=0, busy=0, done=0, hold register empty, wr_ready=1.
- Reset asserted mid-burst forces these values on the next evaluation (asynchronous) and discards both the active and the held burst.
- Hold register: one entry (data+mask). wr_ready = ~hold_full. Accept sets hold_full. Load into the active register clears it.
- An accept and a load in the same cycle leave hold_full=1 with the new burst.
- FSM states: IDLE, CMD, WAIT, PRE, DATA, POST.
- IDLE: if hold_full, load the active register and go to CMD. Handshake-to-CMD latency is 1 cycle.
- CMD (1 cycle): cs=1, ca=CA_WR. Otherwise cs=0, ca=0. Load wait counter with WL-2.
- WAIT (WL-1 cycles): count down to 0, then go to PRE. With cmd at cycle c, PRE starts at c+WL.
- PRE (2 cycles): dqs_oe=1. Cycle P0: dqs_t_r=dqs_t_f=2'b00. Cycle P1: dqs_t_r=2'b11, dqs_t_f=2'b00. dq_oe=0 in both.
- DATA (8 cycles, beat counter i=0..7): dq_oe=dqs_oe=1, dq_r=beat 2i, dq_f=beat 2i+1, dmi likewise, dqs_t_r=2'b11, dqs_t_f=2'b00.
- POST (1 cycle): dqs_oe=1, dqs_t_r=dqs_t_f=0, dq_oe=0, dq=0, done=1.
  - Next state is CMD directly if hold_full (load in this cycle), else IDLE.
- Back-to-back command spacing is WL+11 cycles (cmd at c, next cmd at c+WL+11).
- Beat counter is 3 bits and wraps 7->0 only on the DATA->POST exit.
- Outputs are registered; no combinational path from wr_valid to the pad outputs.
- Only wr_ready is combinational, from the hold flag.

Decomposition:
- Package lp4_pkg: state enum (IDLE, CMD, WAIT, PRE, DATA, POST), CA_RD=6'd2, CA_WR=6'd4, BL=16, PRE_CYC=2, POST_CYC=1.
- Sub-module lp4_wr_hold: one-entry valid/ready holding buffer with load/clear; the rest stays flat.

Test Plan:
- Single burst, WL=6, wr_data beat k = {8'(2k+1), 8'(2k)}, mask 0 -> cs=1/ca=4 at c; dqs_oe rises at c+6; dq_r=16'h0100 and dq_f=16'h0302 at c+8; last pair 16'h1D1C/16'h1F1E at c+15; done at c+16; busy low at c+17.
- Two requests offered back-to-back -> second accepted while first active (wr_ready=0 until load); second cmd exactly at c+17; no idle gap with dqs_oe=0 between POST and the second CMD.
- wr_valid held with hold full -> wr_ready=0, no accept, data unchanged, third burst accepted only after load.
- Reset asserted at DATA beat i=3 -> all outputs 0 immediately; after release busy=0, wr_ready=1, no cmd until a new request.
- WL=2 corner -> WAIT lasts 1 cycle, PRE at c+2; data starts c+4.
- Mask all-ones 32'hFFFFFFFF with data 0xFFFF -> dmi_r=dmi_f=2'b11 for all 8 DATA cycles, 0 outside.

Source files
------------

// File: rtl/lp4_pkg.sv
// lp4_pkg: shared types and constants for the LPDDR4 channel-A write-burst path.
//   state_e  : write transmitter FSM states
//   CA_RD    : CA code for a read command
//   CA_WR    : CA code for a write command
//   BL       : beats per burst (fixed, even)
//   PRE_CYC  : DQS preamble length in CK cycles
//   POST_CYC : DQS postamble length in CK cycles
package lp4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_PRE,
        ST_DATA,
        ST_POST
    } state_e;

    localparam logic [5:0] CA_RD    = 6'd2;
    localparam logic [5:0] CA_WR    = 6'd4;
    localparam int         BL       = 16;
    localparam int         PRE_CYC  = 2;
    localparam int         POST_CYC = 1;

endpackage

// File: rtl/lp4_wr_hold.sv
// lp4_wr_hold: one-entry valid/ready holding buffer for a write burst.
//   CK, RESET_N : clock (rising edge) and asynchronous active-high reset
//   in_valid    : burst offered
//   in_ready    : buffer empty, burst will be taken this cycle
//   in_data     : BL*DQ_W burst data
//   in_mask     : BL*2 byte mask
//   load        : consumer takes the held burst this cycle
//   full        : buffer holds a burst
//   out_data    : held burst data
//   out_mask    : held burst mask
module lp4_wr_hold
    import lp4_pkg::*;
#(
    parameter int DQ_W = 16
) (
    input  logic                CK,
    input  logic                RESET_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BL*DQ_W-1:0]  in_data,
    input  logic [BL*2-1:0]     in_mask,
    input  logic                load,
    output logic                full,
    output logic [BL*DQ_W-1:0]  out_data,
    output logic [BL*2-1:0]     out_mask
);

    logic                full_d, full_q;
    logic                accept;
    logic [BL*DQ_W-1:0]  data_d, data_q;
    logic [BL*2-1:0]     mask_d, mask_q;

    // An accept in the same cycle as a load keeps the buffer full with the
    // newly accepted burst.
    always_comb begin
        accept = in_valid && !full_q;
        full_d = accept || (full_q && !load);
        data_d = accept ? in_data : data_q;
        mask_d = accept ? in_mask : mask_q;
    end

    always_ff @(posedge CK or posedge RESET_N) begin
        if (RESET_N) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset: it is only observed while full_q is set.
    always_ff @(posedge CK) begin
        data_q <= data_d;
        mask_q <= mask_d;
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign out_data = data_q;
    assign out_mask = mask_q;

endmodule

// File: rtl/lp4_wr_burst_tx.sv
// lp4_wr_burst_tx: controller-side LPDDR4 channel-A write-burst transmitter.
// Takes one BL-beat burst per wr_valid/wr_ready handshake, issues the write
// command, and WL cycles later drives DQS preamble, 8 cycles of DDR data
// (rise/fall pairs) and a 1-cycle postamble. RESET_N is active-high despite
// its name.
//   CK, RESET_N       : clock (rising edge), asynchronous active-high reset
//   wr_valid/wr_ready : burst request handshake (wr_ready = hold empty)
//   wr_data, wr_mask  : burst payload, beat k at [DQ_W*k +: DQ_W] / [2k +: 2]
//   cs, ca            : command bus
//   dq_r/dq_f, dmi_r/dmi_f, dq_oe       : rise/fall data, mask, enable
//   dqs_t_r/dqs_t_f, dqs_oe             : DQS_T level per phase, enable
//   busy              : FSM not idle
//   done              : one-cycle pulse in the postamble cycle
module lp4_wr_burst_tx
    import lp4_pkg::*;
#(
    parameter int WL   = 6,
    parameter int DQ_W = 16
) (
    input  logic                CK,
    input  logic                RESET_N,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BL*DQ_W-1:0]  wr_data,
    input  logic [BL*2-1:0]     wr_mask,
    output logic                cs,
    output logic [5:0]          ca,
    output logic [DQ_W-1:0]     dq_r,
    output logic [DQ_W-1:0]     dq_f,
    output logic [1:0]          dmi_r,
    output logic [1:0]          dmi_f,
    output logic                dq_oe,
    output logic [1:0]          dqs_t_r,
    output logic [1:0]          dqs_t_f,
    output logic                dqs_oe,
    output logic                busy,
    output logic                done
);

    // WAIT runs WL-1 cycles counting WL-2 down to 0.
    localparam logic [5:0] WAIT_INIT = 6'(WL - 2);

    state_e              state_d, state_q;
    logic [5:0]          wait_cnt_d, wait_cnt_q;
    logic [2:0]          beat_d, beat_q;
    logic                pre_d, pre_q;
    logic                load;
    logic                hold_full;
    logic [BL*DQ_W-1:0]  hold_data, active_data_d, active_data_q, data_sh;
    logic [BL*2-1:0]     hold_mask, active_mask_d, active_mask_q, mask_sh;

    logic                cs_d, cs_q, dq_oe_d, dq_oe_q, dqs_oe_d, dqs_oe_q;
    logic                busy_d, busy_q, done_d, done_q;
    logic [5:0]          ca_d, ca_q;
    logic [DQ_W-1:0]     dq_r_d, dq_r_q, dq_f_d, dq_f_q;
    logic [1:0]          dmi_r_d, dmi_r_q, dmi_f_d, dmi_f_q;
    logic [1:0]          dqs_t_r_d, dqs_t_r_q, dqs_t_f_d, dqs_t_f_q;

    lp4_wr_hold #(.DQ_W(DQ_W)) u_hold (
        .CK       (CK),
        .RESET_N  (RESET_N),
        .in_valid (wr_valid),
        .in_ready (wr_ready),
        .in_data  (wr_data),
        .in_mask  (wr_mask),
        .load     (load),
        .full     (hold_full),
        .out_data (hold_data),
        .out_mask (hold_mask)
    );

    // Next-state logic. The beat counter increments through DATA so it wraps
    // 7->0 exactly on the DATA->POST exit.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        pre_d      = pre_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 6'd0) begin
                    pre_d   = 1'b0;
                    state_d = ST_PRE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 6'd1;
                end
            end
            ST_PRE: begin
                if (pre_q == 1'(PRE_CYC - 1)) begin
                    beat_d  = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    pre_d = 1'b1;
                end
            end
            ST_DATA: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'(BL / 2 - 1)) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                // A waiting burst goes straight to CMD with no idle gap.
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        active_data_d = load ? hold_data : active_data_q;
        active_mask_d = load ? hold_mask : active_mask_q;
    end

    // Output decode from the next state so every pad output is a flop.
    always_comb begin
        data_sh   = active_data_q >> (2 * DQ_W * int'(beat_d));
        mask_sh   = active_mask_q >> (4 * int'(beat_d));
        cs_d      = (state_d == ST_CMD);
        ca_d      = cs_d ? CA_WR : 6'd0;
        dq_oe_d   = (state_d == ST_DATA);
        dqs_oe_d  = (state_d == ST_PRE) || (state_d == ST_DATA) || (state_d == ST_POST);
        dqs_t_r_d = (dq_oe_d || (state_d == ST_PRE && pre_d)) ? 2'b11 : 2'b00;
        dqs_t_f_d = 2'b00;
        dq_r_d    = dq_oe_d ? data_sh[DQ_W-1:0] : '0;
        dq_f_d    = dq_oe_d ? data_sh[2*DQ_W-1:DQ_W] : '0;
        dmi_r_d   = dq_oe_d ? mask_sh[1:0] : 2'b00;
        dmi_f_d   = dq_oe_d ? mask_sh[3:2] : 2'b00;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_POST);
    end

    always_ff @(posedge CK or posedge RESET_N) begin
        if (RESET_N) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 6'd0;
            beat_q     <= 3'd0;
            pre_q      <= 1'b0;
            cs_q       <= 1'b0;
            ca_q       <= 6'd0;
            dq_r_q     <= '0;
            dq_f_q     <= '0;
            dmi_r_q    <= 2'b00;
            dmi_f_q    <= 2'b00;
            dq_oe_q    <= 1'b0;
            dqs_t_r_q  <= 2'b00;
            dqs_t_f_q  <= 2'b00;
            dqs_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            pre_q      <= pre_d;
            cs_q       <= cs_d;
            ca_q       <= ca_d;
            dq_r_q     <= dq_r_d;
            dq_f_q     <= dq_f_d;
            dmi_r_q    <= dmi_r_d;
            dmi_f_q    <= dmi_f_d;
            dq_oe_q    <= dq_oe_d;
            dqs_t_r_q  <= dqs_t_r_d;
            dqs_t_f_q  <= dqs_t_f_d;
            dqs_oe_q   <= dqs_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge CK) begin
        active_data_q <= active_data_d;
        active_mask_q <= active_mask_d;
    end

    assign cs      = cs_q;
    assign ca      = ca_q;
    assign dq_r    = dq_r_q;
    assign dq_f    = dq_f_q;
    assign dmi_r   = dmi_r_q;
    assign dmi_f   = dmi_f_q;
    assign dq_oe   = dq_oe_q;
    assign dqs_t_r = dqs_t_r_q;
    assign dqs_t_f = dqs_t_f_q;
    assign dqs_oe  = dqs_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lp4_wr_burst_tx.sv
`timescale 1ns/1ps
module tb_lp4_wr_burst_tx;
    import lp4_pkg::*;

    localparam int DQ_W = 16;
    localparam int DW   = BL * DQ_W;
    localparam int MW   = BL * 2;
    localparam int NU   = 2;
    localparam int WL0  = 6;
    localparam int WL1  = 2;

    int wl_m [NU] = '{WL0, WL1};

    logic          CK = 1'b0;
    logic          RESET_N;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;

    logic            wr_ready [NU];
    logic            cs [NU], dq_oe [NU], dqs_oe [NU], busy [NU], done [NU];
    logic [5:0]      ca [NU];
    logic [DQ_W-1:0] dq_r [NU], dq_f [NU];
    logic [1:0]      dmi_r [NU], dmi_f [NU], dqs_t_r [NU], dqs_t_f [NU];

    always #5 CK = ~CK;

    lp4_wr_burst_tx #(.WL(WL0), .DQ_W(DQ_W)) u_dut_wl6 (
        .CK(CK), .RESET_N(RESET_N), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
        .wr_data(wr_data), .wr_mask(wr_mask), .cs(cs[0]), .ca(ca[0]),
        .dq_r(dq_r[0]), .dq_f(dq_f[0]), .dmi_r(dmi_r[0]), .dmi_f(dmi_f[0]),
        .dq_oe(dq_oe[0]), .dqs_t_r(dqs_t_r[0]), .dqs_t_f(dqs_t_f[0]),
        .dqs_oe(dqs_oe[0]), .busy(busy[0]), .done(done[0])
    );

    lp4_wr_burst_tx #(.WL(WL1), .DQ_W(DQ_W)) u_dut_wl2 (
        .CK(CK), .RESET_N(RESET_N), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
        .wr_data(wr_data), .wr_mask(wr_mask), .cs(cs[1]), .ca(ca[1]),
        .dq_r(dq_r[1]), .dq_f(dq_f[1]), .dmi_r(dmi_r[1]), .dmi_f(dmi_f[1]),
        .dq_oe(dq_oe[1]), .dqs_t_r(dqs_t_r[1]), .dqs_t_f(dqs_t_f[1]),
        .dqs_oe(dqs_oe[1]), .busy(busy[1]), .done(done[1])
    );

    // Reference model: a burst is described by its command cycle; every
    // output follows from the offset of the current cycle from that command.
    bit            m_hf  [NU];
    logic [DW-1:0] m_hd  [NU];
    logic [MW-1:0] m_hm  [NU];
    bit            m_act [NU];
    int            m_cmd [NU];
    logic [DW-1:0] m_ad  [NU];
    logic [MW-1:0] m_am  [NU];

    int cyc;
    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit live(int u);
        int o;
        o = cyc - m_cmd[u];
        return m_act[u] && (o >= 0) && (o <= wl_m[u] + 10);
    endfunction

    task automatic check_all();
        for (int u = 0; u < NU; u++) begin
            int              o, wl, j;
            bit              lv, dat;
            logic [DQ_W-1:0] e_dqr, e_dqf;
            logic [1:0]      e_mr, e_mf;
            string           p;
            wl  = wl_m[u];
            o   = cyc - m_cmd[u];
            lv  = live(u);
            dat = lv && (o >= wl + 2) && (o <= wl + 9);
            j   = o - wl - 2;
            e_dqr = '0; e_dqf = '0; e_mr = 2'b00; e_mf = 2'b00;
            if (dat) begin
                e_dqr = m_ad[u][DQ_W*(2*j)   +: DQ_W];
                e_dqf = m_ad[u][DQ_W*(2*j+1) +: DQ_W];
                e_mr  = m_am[u][2*(2*j)   +: 2];
                e_mf  = m_am[u][2*(2*j+1) +: 2];
            end
            p = $sformatf("wl%0d_", wl);
            chk({p, "ready"},   64'(wr_ready[u]), 64'(!m_hf[u]));
            chk({p, "cs"},      64'(cs[u]),       64'(lv && o == 0));
            chk({p, "ca"},      64'(ca[u]),       (lv && o == 0) ? 64'd4 : 64'd0);
            chk({p, "busy"},    64'(busy[u]),     64'(lv));
            chk({p, "done"},    64'(done[u]),     64'(lv && o == wl + 10));
            chk({p, "dqs_oe"},  64'(dqs_oe[u]),   64'(lv && o >= wl && o <= wl + 10));
            chk({p, "dqs_t_r"}, 64'(dqs_t_r[u]),  (lv && (o == wl + 1 || dat)) ? 64'd3 : 64'd0);
            chk({p, "dqs_t_f"}, 64'(dqs_t_f[u]),  64'd0);
            chk({p, "dq_oe"},   64'(dq_oe[u]),    64'(dat));
            chk({p, "dq_r"},    64'(dq_r[u]),     64'(e_dqr));
            chk({p, "dq_f"},    64'(dq_f[u]),     64'(e_dqf));
            chk({p, "dmi_r"},   64'(dmi_r[u]),    64'(e_mr));
            chk({p, "dmi_f"},   64'(dmi_f[u]),    64'(e_mf));
        end
    endtask

    task automatic model_edge();
        for (int u = 0; u < NU; u++) begin
            bit lv, post, ld, acc;
            if (RESET_N) begin
                m_hf[u]  = 1'b0;
                m_act[u] = 1'b0;
            end else begin
                lv   = live(u);
                post = lv && ((cyc - m_cmd[u]) == wl_m[u] + 10);
                ld   = m_hf[u] && (!lv || post);
                acc  = wr_valid && !m_hf[u];
                if (ld) begin
                    m_act[u] = 1'b1;
                    m_cmd[u] = cyc + 1;
                    m_ad[u]  = m_hd[u];
                    m_am[u]  = m_hm[u];
                end
                if (acc) begin
                    m_hd[u] = wr_data;
                    m_hm[u] = wr_mask;
                end
                m_hf[u] = acc || (m_hf[u] && !ld);
            end
        end
    endtask

    // Inputs change at the falling edge, outputs are checked at the next one.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wr_valid = v;
        wr_data  = d;
        wr_mask  = m;
        @(posedge CK);
        model_edge();
        cyc++;
        @(negedge CK);
        check_all();
    endtask

    function automatic logic [DW-1:0] pat_data();
        logic [DW-1:0] d;
        for (int k = 0; k < BL; k++) d[DQ_W*k +: DQ_W] = {8'(2*k+1), 8'(2*k)};
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b, c;
        bit            reached;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int u = 0; u < NU; u++) begin
            m_hf[u] = 1'b0; m_act[u] = 1'b0; m_cmd[u] = 0;
            m_hd[u] = '0; m_hm[u] = '0; m_ad[u] = '0; m_am[u] = '0;
        end
        RESET_N  = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_mask  = '0;
        @(negedge CK);
        check_all();
        for (int k = 0; k < 3; k++) cycle(1'b1, rand_data(), 32'h0);
        RESET_N = 1'b0;
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0);

        // Single burst with the counting pattern.
        cycle(1'b1, pat_data(), 32'h0);
        for (int k = 0; k < 30; k++) cycle(1'b0, '0, '0);

        // Back-to-back requests, then a third held until it is taken.
        a = rand_data(); b = rand_data(); c = rand_data();
        cycle(1'b1, a, 32'h1234_5678);
        for (int k = 0; k < 3; k++) cycle(1'b1, b, 32'h9ABC_DEF0);
        for (int k = 0; k < 25; k++) cycle(1'b1, c, 32'h0F0F_A5A5);
        for (int k = 0; k < 70; k++) cycle(1'b0, '0, '0);

        // Mask all ones with all-ones data.
        cycle(1'b1, {DW{1'b1}}, 32'hFFFF_FFFF);
        for (int k = 0; k < 30; k++) cycle(1'b0, '0, '0);

        // Randomized traffic.
        for (int k = 0; k < 700; k++) begin
            cycle(($urandom_range(0, 3) == 0), rand_data(), $urandom());
        end
        for (int k = 0; k < 40; k++) cycle(1'b0, '0, '0);

        // Reset in the middle of DATA beat 3 with a second burst held.
        cycle(1'b1, rand_data(), $urandom());
        b = rand_data();
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            cycle(1'b1, b, 32'h5555_AAAA);
            reached = live(0) && ((cyc - m_cmd[0]) == WL0 + 5);
        end
        chk("rst_reach_beat3", 64'(reached), 64'd1);
        #2;
        RESET_N = 1'b1;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk("async_rst_cs",      64'(cs[u]),      64'd0);
            chk("async_rst_ca",      64'(ca[u]),      64'd0);
            chk("async_rst_dq_oe",   64'(dq_oe[u]),   64'd0);
            chk("async_rst_dq_r",    64'(dq_r[u]),    64'd0);
            chk("async_rst_dq_f",    64'(dq_f[u]),    64'd0);
            chk("async_rst_dmi_r",   64'(dmi_r[u]),   64'd0);
            chk("async_rst_dqs_oe",  64'(dqs_oe[u]),  64'd0);
            chk("async_rst_dqs_t_r", 64'(dqs_t_r[u]), 64'd0);
            chk("async_rst_busy",    64'(busy[u]),    64'd0);
            chk("async_rst_done",    64'(done[u]),    64'd0);
            chk("async_rst_ready",   64'(wr_ready[u]), 64'd1);
            m_hf[u]  = 1'b0;
            m_act[u] = 1'b0;
        end
        for (int k = 0; k < 2; k++) cycle(1'b0, '0, '0);
        RESET_N = 1'b0;
        for (int k = 0; k < 30; k++) cycle(1'b0, '0, '0);
        cycle(1'b1, pat_data(), 32'hFFFF_0000);
        for (int k = 0; k < 30; k++) cycle(1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
